// File: rtl/fb_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_mode_sequencer_if
// Description : Bus bundle between the mode sequencer, switches, copier and
//               the framebuffer write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_mode_sequencer_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int SW_W   = 4
);
    logic [SW_W-1:0]   sw;
    logic [SW_W-1:0]   mode;
    logic              cop_start;
    logic              cop_done;
    logic [ADDR_W-1:0] cop_wraddr;
    logic [DATA_W-1:0] cop_data;
    logic              cop_wren;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              display_en;
    logic              busy;

    // Sequencer side.
    modport master (
        input  sw, cop_done, cop_wraddr, cop_data, cop_wren,
        output mode, cop_start, ram_wraddr, ram_data, ram_wren, display_en, busy
    );

    // Environment side: switches, copier, RAM and display gate.
    modport slave (
        output sw, cop_done, cop_wraddr, cop_data, cop_wren,
        input  mode, cop_start, ram_wraddr, ram_data, ram_wren, display_en, busy
    );
endinterface
`default_nettype wire

// File: rtl/fb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fb_mode_sequencer
// Description : Debounces the mode switches and sequences clear -> copier
//               restart -> display for each committed mode. Optional macro
//               FB_CLEAR_EN enables the internal framebuffer clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_mode_sequencer #(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int SW_W          = 4,
    parameter int CLEAR_DEPTH   = 307200,
    parameter int STABLE_CYCLES = 1000000,
    parameter int START_LEN     = 2
) (
    input  wire                 clk_50MHz,
    input  wire                 vga_reset,
    fb_mode_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SL_W  = $clog2(START_LEN + 1);

    localparam logic [CNT_W-1:0]  c_stable_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [SL_W-1:0]   c_start_last  = SL_W'(START_LEN - 1);
`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_clear_last  = ADDR_W'(CLEAR_DEPTH - 1);
`endif

`ifdef FB_CLEAR_EN
    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_CLEAR = 3'd1,
        S_START = 3'd2,
        S_COPY  = 3'd3,
        S_RUN   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_START = 3'd2,
        S_COPY  = 3'd3,
        S_RUN   = 3'd4
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;

    logic [SW_W-1:0]   r_sw_s1;
    logic [SW_W-1:0]   r_sw_s2;
    logic [SW_W-1:0]   r_cand;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done_d;
    logic              r_done_pend;
    logic [SL_W-1:0]   r_start_cnt;

    logic [SW_W-1:0]   r_mode;
    logic              r_cop_start;
    logic [ADDR_W-1:0] r_ram_wraddr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    logic              r_display_en;
    logic              r_busy;

    logic              w_stable;
    logic              w_req;
    logic              w_done_rise;

    logic [SW_W-1:0]   w_mode_nxt;
    logic              w_cop_start_nxt;
    logic [ADDR_W-1:0] w_ram_wraddr_nxt;
    logic [DATA_W-1:0] w_ram_data_nxt;
    logic              w_ram_wren_nxt;
    logic              w_display_en_nxt;
    logic              w_busy_nxt;
    logic [SL_W-1:0]   w_start_cnt_nxt;
    logic              w_done_pend_nxt;

    assign w_stable    = (r_cnt == c_stable_last);
    assign w_req       = w_stable && (r_cand != r_mode);
    assign w_done_rise = bus.cop_done && !r_done_d;

    // Switch synchroniser and debounce.
    always_ff @(posedge clk_50MHz or negedge vga_reset) begin
        if (!vga_reset) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_done_d <= 1'b0;
        end else begin
            r_sw_s1  <= bus.sw;
            r_sw_s2  <= r_sw_s1;
            r_done_d <= bus.cop_done;
            if (r_sw_s2 != r_cand) begin
                r_cand <= r_sw_s2;
                r_cnt  <= '0;
            end else if (!w_stable) begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // State and registered outputs: each output register loads the value
    // belonging to the state being entered, so outputs track r_state.
    always_ff @(posedge clk_50MHz or negedge vga_reset) begin
        if (!vga_reset) begin
            r_state      <= S_BOOT;
            r_mode       <= '0;
            r_cop_start  <= 1'b0;
            r_ram_wraddr <= '0;
            r_ram_data   <= '0;
            r_ram_wren   <= 1'b0;
            r_display_en <= 1'b0;
            r_busy       <= 1'b0;
            r_start_cnt  <= '0;
            r_done_pend  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_cop_start  <= w_cop_start_nxt;
            r_ram_wraddr <= w_ram_wraddr_nxt;
            r_ram_data   <= w_ram_data_nxt;
            r_ram_wren   <= w_ram_wren_nxt;
            r_display_en <= w_display_en_nxt;
            r_busy       <= w_busy_nxt;
            r_start_cnt  <= w_start_cnt_nxt;
            r_done_pend  <= w_done_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_cop_start_nxt  = r_cop_start;
        w_ram_wraddr_nxt = r_ram_wraddr;
        w_ram_data_nxt   = r_ram_data;
        w_ram_wren_nxt   = r_ram_wren;
        w_display_en_nxt = r_display_en;
        w_busy_nxt       = r_busy;
        w_start_cnt_nxt  = r_start_cnt;
        w_done_pend_nxt  = r_done_pend;

        case (r_state)
            S_BOOT: begin
                w_busy_nxt = 1'b1;
`ifdef FB_CLEAR_EN
                w_state_nxt      = S_CLEAR;
                w_ram_wren_nxt   = 1'b1;
                w_ram_wraddr_nxt = '0;
                w_ram_data_nxt   = '0;
`else
                w_state_nxt      = S_START;
                w_cop_start_nxt  = 1'b1;
                w_start_cnt_nxt  = '0;
                w_done_pend_nxt  = 1'b0;
`endif
            end

`ifdef FB_CLEAR_EN
            S_CLEAR: begin
                if (r_ram_wraddr == c_clear_last) begin
                    w_state_nxt     = S_START;
                    w_ram_wren_nxt  = 1'b0;
                    w_cop_start_nxt = 1'b1;
                    w_start_cnt_nxt = '0;
                    w_done_pend_nxt = 1'b0;
                end else begin
                    w_ram_wraddr_nxt = r_ram_wraddr + 1'b1;
                end
            end
`endif

            S_START: begin
                // An edge seen while the pulse is still out is kept for S_COPY.
                if (w_done_rise) begin
                    w_done_pend_nxt = 1'b1;
                end
                if (r_start_cnt == c_start_last) begin
                    w_state_nxt     = S_COPY;
                    w_cop_start_nxt = 1'b0;
                end else begin
                    w_start_cnt_nxt = r_start_cnt + 1'b1;
                end
            end

            S_COPY: begin
                w_ram_wraddr_nxt = bus.cop_wraddr;
                w_ram_data_nxt   = bus.cop_data;
                w_ram_wren_nxt   = bus.cop_wren;
                if (w_done_rise || r_done_pend) begin
                    w_state_nxt      = S_RUN;
                    w_ram_wren_nxt   = 1'b0;
                    w_display_en_nxt = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_done_pend_nxt  = 1'b0;
                end
            end

            S_RUN: begin
                w_ram_wren_nxt = 1'b0;
                if (w_req) begin
                    w_mode_nxt       = r_cand;
                    w_display_en_nxt = 1'b0;
                    w_busy_nxt       = 1'b1;
`ifdef FB_CLEAR_EN
                    w_state_nxt      = S_CLEAR;
                    w_ram_wren_nxt   = 1'b1;
                    w_ram_wraddr_nxt = '0;
                    w_ram_data_nxt   = '0;
`else
                    w_state_nxt      = S_START;
                    w_cop_start_nxt  = 1'b1;
                    w_start_cnt_nxt  = '0;
                    w_done_pend_nxt  = 1'b0;
`endif
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign bus.mode       = r_mode;
    assign bus.cop_start  = r_cop_start;
    assign bus.ram_wraddr = r_ram_wraddr;
    assign bus.ram_data   = r_ram_data;
    assign bus.ram_wren   = r_ram_wren;
    assign bus.display_en = r_display_en;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_mode_sequencer
// Description : Self-checking bench; framebuffer writes are scoreboarded,
//               control outputs checked at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_mode_sequencer;

    localparam int c_addr_w = 19;
    localparam int c_data_w = 8;
`ifdef FB_CLEAR_EN
    localparam int c_clr_lat = 16;
`else
    localparam int c_clr_lat = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [c_addr_w+c_data_w-1:0] wq[$];

    fb_mode_sequencer_if #(.ADDR_W(c_addr_w), .DATA_W(c_data_w), .SW_W(4)) bus ();

    fb_mode_sequencer #(
        .ADDR_W(c_addr_w), .DATA_W(c_data_w), .SW_W(4),
        .CLEAR_DEPTH(16), .STABLE_CYCLES(4), .START_LEN(2)
    ) u_dut (
        .clk_50MHz(clk),
        .vga_reset(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write that reaches the RAM port must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.ram_wren) begin
            check("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                check("wr_addr_data", {bus.ram_wraddr, bus.ram_data}, wq.pop_front());
            end
        end
    end

    task automatic push_clear();
`ifdef FB_CLEAR_EN
        for (int i = 0; i < 16; i++) wq.push_back({19'(i), 8'h00});
`endif
    endtask

    // Counts falling edges until cop_start, then measures its width.
    task automatic wait_start(input int exp_lat);
        int n = 0;
        int h = 0;
        while (!bus.cop_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", n, exp_lat);
        while (bus.cop_start && h < 10) begin
            check("busy_in_start", bus.busy, 1'b1);
            h++;
            @(negedge clk);
        end
        check("start_width", h, 2);
        check("queue_drained", wq.size(), 0);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.sw = '0;
        bus.cop_done = 1'b0;
        bus.cop_wraddr = '0;
        bus.cop_data = '0;
        bus.cop_wren = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.mode, bus.cop_start, bus.ram_wraddr, bus.ram_data,
                              bus.ram_wren, bus.display_en, bus.busy}, '0);

        // Boot pass: clear then copier restart.
        push_clear();
        rst_n = 1'b1;
        wait_start(c_clr_lat + 1);
        check("boot_mode", bus.mode, 4'h0);
        check("boot_disp", bus.display_en, 1'b0);

        // Copier passthrough in S_COPY.
        bus.cop_wren = 1'b1; bus.cop_wraddr = 19'd5; bus.cop_data = 8'hAB;
        wq.push_back({19'd5, 8'hAB});
        @(negedge clk);
        bus.cop_wraddr = 19'd9; bus.cop_data = 8'h3C;
        wq.push_back({19'd9, 8'h3C});
        @(negedge clk);
        bus.cop_wren = 1'b0;
        @(negedge clk);
        check("copy_drained", wq.size(), 0);
        bus.cop_done = 1'b1;
        @(negedge clk);
        check("run_disp", bus.display_en, 1'b1);
        check("run_busy", bus.busy, 1'b0);

        // In S_RUN copier writes are blocked.
        bus.cop_wren = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("run_no_wren", bus.ram_wren, 1'b0);
        end
        bus.cop_wren = 1'b0;
        bus.cop_done = 1'b0;

        // Short glitch must not commit.
        bus.sw = 4'b0001;
        repeat (3) @(negedge clk);
        bus.sw = 4'b0000;
        repeat (10) @(negedge clk);
        check("glitch_mode", bus.mode, 4'h0);
        check("glitch_disp", bus.display_en, 1'b1);

        // Stable change commits.
        push_clear();
        bus.sw = 4'b0001;
        n = 0;
        while (bus.mode != 4'h1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("commit_latency", n, 7);
        check("commit_disp", bus.display_en, 1'b0);
        check("commit_busy", bus.busy, 1'b1);
        wait_start(c_clr_lat);

        // Change during S_COPY is deferred until the copy completes.
        bus.sw = 4'b1010;
        repeat (20) @(negedge clk);
        check("defer_mode", bus.mode, 4'h1);
        check("defer_busy", bus.busy, 1'b1);
        push_clear();
        bus.cop_done = 1'b1;
        @(negedge clk);
        check("short_run_disp", bus.display_en, 1'b1);
        check("short_run_mode", bus.mode, 4'h1);
        @(negedge clk);
        check("recommit_disp", bus.display_en, 1'b0);
        check("recommit_mode", bus.mode, 4'hA);
        check("recommit_busy", bus.busy, 1'b1);

        // Reset in the middle of a pass.
`ifdef FB_CLEAR_EN
        n = 0;
        while (bus.ram_wraddr != 19'd7 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("clear_reach_7", bus.ram_wraddr, 19'd7);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {bus.mode, bus.cop_start, bus.ram_wraddr, bus.ram_data,
                                 bus.ram_wren, bus.display_en, bus.busy}, '0);
        wq.delete();
        bus.sw = 4'b0000;
        bus.cop_done = 1'b0;
        repeat (3) @(negedge clk);
        push_clear();
        rst_n = 1'b1;
        wait_start(c_clr_lat + 1);
        check("reboot_mode", bus.mode, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
